// File: rtl/fmul_share_arbiter.sv
// Round-robin sharing of one pipelined FP multiplier among NREQ requesters, results tagged by id.
// Optional perf counters under FMUL_SHARE_ARB_PERF_EN; a blocked result freezes the whole pipe.
module fmul_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MUL_LAT = 2
) (
  input  logic                 i_clk,
  input  logic                 i_clrn,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [32*NREQ-1:0]   i_req_a,
  input  logic [32*NREQ-1:0]   i_req_b,
  output logic [31:0]          o_mul_a,
  output logic [31:0]          o_mul_b,
  output logic                 o_mul_en,
  input  logic [31:0]          i_mul_z,
  input  logic                 i_mul_exc,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic [IDW-1:0]       o_res_id,
  output logic [31:0]          o_res_z,
  output logic                 o_res_exc,
  output logic                 o_busy
`ifdef FMUL_SHARE_ARB_PERF_EN
  ,
  output logic [31:0]          o_perf_issue,
  output logic [31:0]          o_perf_stall
`endif
);

  logic [MUL_LAT-1:0] r_vld;
  logic [IDW-1:0]     r_tag [MUL_LAT];
  logic [IDW-1:0]     r_last;

  logic               w_stall;
  logic               w_found;
  logic [IDW-1:0]     w_gid;
  logic [NREQ-1:0]    w_grant;

  assign w_stall = r_vld[MUL_LAT-1] & ~i_res_ready;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int             idx;
    logic [IDW-1:0] cand;
    w_found = 1'b0;
    w_gid   = '0;
    w_grant = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(r_last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = idx[IDW-1:0];
      if (!w_found && !w_stall && i_req_valid[cand]) begin
        w_found = 1'b1;
        w_gid   = cand;
      end
    end
    if (w_found) w_grant[w_gid] = 1'b1;
  end

  assign o_req_ready = w_grant;
  assign o_mul_a     = w_found ? i_req_a[32*w_gid +: 32] : 32'd0;
  assign o_mul_b     = w_found ? i_req_b[32*w_gid +: 32] : 32'd0;
  assign o_mul_en    = ~w_stall;

  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_vld  <= '0;
      r_last <= IDW'(NREQ - 1);
      for (int k = 0; k < MUL_LAT; k++) r_tag[k] <= '0;
    end else if (!w_stall) begin
      r_vld[0] <= w_found;
      r_tag[0] <= w_gid;
      for (int k = 1; k < MUL_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_tag[k] <= r_tag[k-1];
      end
      if (w_found) r_last <= w_gid;
    end
  end

  assign o_res_valid = r_vld[MUL_LAT-1];
  assign o_res_id    = r_tag[MUL_LAT-1];
  assign o_res_z     = i_mul_z;
  assign o_res_exc   = i_mul_exc;
  assign o_busy      = |r_vld;

`ifdef FMUL_SHARE_ARB_PERF_EN
  logic [31:0] r_perf_issue;
  logic [31:0] r_perf_stall;

  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_perf_issue <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_found) r_perf_issue <= r_perf_issue + 32'd1;
      if (w_stall) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign o_perf_issue = r_perf_issue;
  assign o_perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_fmul_share_arbiter.sv
// Directed bench for fmul_share_arbiter with a two-stage multiplier model and a result scoreboard.
module tb_fmul_share_arbiter;

  logic         i_clk;
  logic         i_clrn;
  logic [3:0]   i_req_valid;
  logic [3:0]   o_req_ready;
  logic [127:0] i_req_a;
  logic [127:0] i_req_b;
  logic [31:0]  o_mul_a;
  logic [31:0]  o_mul_b;
  logic         o_mul_en;
  logic [31:0]  i_mul_z;
  logic         i_mul_exc;
  logic         o_res_valid;
  logic         i_res_ready;
  logic [1:0]   o_res_id;
  logic [31:0]  o_res_z;
  logic         o_res_exc;
  logic         o_busy;
`ifdef FMUL_SHARE_ARB_PERF_EN
  logic [31:0]  o_perf_issue;
  logic [31:0]  o_perf_stall;
`endif

  logic [31:0] a [4];
  logic [31:0] b [4];
  assign i_req_a = {a[3], a[2], a[1], a[0]};
  assign i_req_b = {b[3], b[2], b[1], b[0]};

  fmul_share_arbiter #(.NREQ(4), .IDW(2), .MUL_LAT(2)) dut (
    .i_clk(i_clk), .i_clrn(i_clrn),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_a(i_req_a), .i_req_b(i_req_b),
    .o_mul_a(o_mul_a), .o_mul_b(o_mul_b), .o_mul_en(o_mul_en),
    .i_mul_z(i_mul_z), .i_mul_exc(i_mul_exc),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_id(o_res_id), .o_res_z(o_res_z), .o_res_exc(o_res_exc),
    .o_busy(o_busy)
`ifdef FMUL_SHARE_ARB_PERF_EN
    , .o_perf_issue(o_perf_issue), .o_perf_stall(o_perf_stall)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Only the operand pairs the stimulus uses need exact IEEE products.
  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    if (x == 32'd0 || y == 32'd0) return 32'd0;
    if (x == 32'h3F800000) return y;
    if (y == 32'h3F800000) return x;
    if (x == 32'h40400000 && y == 32'h40000000) return 32'h40C00000;
    return 32'hDEADBEEF;
  endfunction

  logic [31:0] s0, s1;
  always @(posedge i_clk) begin
    if (o_mul_en) begin
      s0 <= fmul(o_mul_a, o_mul_b);
      s1 <= s0;
    end
  end
  assign i_mul_z   = s1;
  assign i_mul_exc = 1'b0;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] z;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  int   n_pop  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [3:0] exp_rdy);
    exp_t e;
    @(negedge i_clk);
    chk("req_ready", 32'(o_req_ready), 32'(exp_rdy));
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) begin
        e.id = 2'(i);
        e.z  = fmul(a[i], b[i]);
        sb.push_back(e);
      end
    end
    if (o_res_valid && i_res_ready) begin
      if (sb.size() == 0) begin
        chk("res_valid_unexpected", 32'(o_res_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("res_id", 32'(o_res_id), 32'(e.id));
        chk("res_z", o_res_z, e.z);
        chk("res_exc", 32'(o_res_exc), 32'd0);
        n_pop++;
      end
    end
  endtask

  task automatic adv();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_reset();
    i_clrn = 1'b0;
    #1;
    chk("rst_res_valid", 32'(o_res_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    sb.delete();
    adv();
    i_clrn = 1'b1;
  endtask

  initial begin
    i_clrn      = 1'b1;
    i_req_valid = 4'b0000;
    i_res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin a[i] = 32'd0; b[i] = 32'd0; end
    #2 i_clrn = 1'b0;
    #1;
    chk("rst_res_valid", 32'(o_res_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_req_ready", 32'(o_req_ready), 32'd0);
    chk("rst_mul_en", 32'(o_mul_en), 32'd1);
    chk("rst_res_id", 32'(o_res_id), 32'd0);
    adv();
    i_clrn = 1'b1;

    // Single op with two-cycle latency.
    a[0] = 32'h3F800000; b[0] = 32'h40000000; i_req_valid = 4'b0001;
    sample(4'b0001);
    chk("single_mul_a", o_mul_a, 32'h3F800000);
    chk("single_mul_b", o_mul_b, 32'h40000000);
    adv();
    i_req_valid = 4'b0000;
    sample(4'b0000);
    chk("single_busy", 32'(o_busy), 32'd1);
    chk("bubble_mul_a", o_mul_a, 32'd0);
    chk("single_not_yet", 32'(o_res_valid), 32'd0);
    adv();
    sample(4'b0000);
    chk("single_res_valid", 32'(o_res_valid), 32'd1);
    adv();
    sample(4'b0000);
    chk("single_idle", 32'(o_busy), 32'd0);
    adv();

    // Round robin over all four, continuing after requester 0.
    b[0] = 32'h40000000; b[1] = 32'h40400000; b[2] = 32'h40800000; b[3] = 32'h40A00000;
    for (int i = 0; i < 4; i++) a[i] = 32'h3F800000;
    i_req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      sample(4'(1 << ((i + 1) % 4)));
      if (i >= 2) chk("rr_one_per_cycle", 32'(o_res_valid), 32'd1);
      adv();
    end
    i_req_valid = 4'b0000;
    sample(4'b0000); adv();
    sample(4'b0000); adv();

    // Fairness skip with last winner 0.
    i_req_valid = 4'b0101;
    sample(4'b0100); adv();
    sample(4'b0001); adv();
    sample(4'b0100); adv();
    i_req_valid = 4'b0000;
    sample(4'b0000); adv();
    sample(4'b0000); adv();

    // Reset with two ops in flight, then priority back at requester 0.
    i_req_valid = 4'b0011;
    sample(4'b0001); adv();
    sample(4'b0010); adv();
    i_req_valid = 4'b0000;
    pulse_reset();
    i_req_valid = 4'b1111;
    sample(4'b0001); adv();
    i_req_valid = 4'b0000;
    sample(4'b0000); adv();
    sample(4'b0000); adv();

    // Back-pressure from a fresh reset so the perf counters start at zero.
    pulse_reset();
    n_pop = 0;
    a[0] = 32'h40400000; b[0] = 32'h40000000; i_req_valid = 4'b0001;
    sample(4'b0001); adv();
    sample(4'b0001); adv();
    i_res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample(4'b0000);
      chk("bp_mul_en", 32'(o_mul_en), 32'd0);
      chk("bp_res_valid", 32'(o_res_valid), 32'd1);
      chk("bp_res_z", o_res_z, 32'h40C00000);
      chk("bp_res_id", 32'(o_res_id), 32'd0);
      adv();
    end
    i_res_ready = 1'b1;
    sample(4'b0001);
    chk("bp_release_mul_en", 32'(o_mul_en), 32'd1);
    adv();
    sample(4'b0001); adv();
    i_req_valid = 4'b0000;
    sample(4'b0000); adv();
    sample(4'b0000); adv();
    chk("bp_result_count", 32'(n_pop), 32'd4);
    chk("bp_idle", 32'(o_busy), 32'd0);
`ifdef FMUL_SHARE_ARB_PERF_EN
    chk("perf_issue", o_perf_issue, 32'd4);
    chk("perf_stall", o_perf_stall, 32'd3);
`endif
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
